// File: rtl/sys_mem_arb.sv
// ============================================================================
// Module   : sys_mem_arb
// Purpose  : Burst round-robin arbiter of two requesters onto the system-memory
//            master port, with an in-order read-return tag FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_mem_arb #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 27,
    parameter int BURST_LEN     = 16,
    parameter int MAX_RD_OUTSTD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_rden,
    input  logic              m0_wren,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_wait,
    output logic              m0_rd_valid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_rden,
    input  logic              m1_wren,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_wait,
    output logic              m1_rd_valid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              sys_mem_wait,
    output logic              sys_mem_rden,
    output logic              sys_mem_wren,
    output logic [ADDR_W-1:0] sys_mem_addr,
    output logic [DATA_W-1:0] sys_mem_wdata,
    input  logic              sys_mem_rd_valid,
    input  logic [DATA_W-1:0] sys_mem_rdata,
    output logic [1:0]        gnt,
    output logic              rd_err
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int OUT_W = $clog2(MAX_RD_OUTSTD + 1);
    localparam int PTR_W = (MAX_RD_OUTSTD > 1) ? $clog2(MAX_RD_OUTSTD) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [OUT_W-1:0] OUT_FULL   = OUT_W'(MAX_RD_OUTSTD);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_RD_OUTSTD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               tag_q [MAX_RD_OUTSTD];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0]   outstd_q, outstd_d;
    logic               rd_err_q, rd_err_d;

    logic               w_req0, w_req1, w_granted, w_sel;
    logic               w_cur_rden, w_cur_wren, w_cur_req, w_other_req;
    logic               w_rd_block, w_port_wait, w_mem_acc;
    logic               w_end_idle, w_end_burst, w_grant_start;
    logic               w_push, w_pop, w_has_tag, w_head;

    assign w_req0      = m0_rden | m0_wren;
    assign w_req1      = m1_rden | m1_wren;
    assign w_granted   = (state_q != IDLE);
    assign w_sel       = (state_q == GNT1);
    assign w_cur_rden  = w_sel ? m1_rden : m0_rden;
    assign w_cur_wren  = w_sel ? m1_wren : m0_wren;
    assign w_cur_req   = w_sel ? w_req1 : w_req0;
    assign w_other_req = w_sel ? w_req0 : w_req1;

    // Reads stall at the outstanding limit; writes keep flowing.
    assign w_rd_block  = w_granted & w_cur_rden & (outstd_q == OUT_FULL);
    assign w_port_wait = sys_mem_wait | w_rd_block;

    assign sys_mem_rden  = w_granted & w_cur_rden & ~w_rd_block;
    assign sys_mem_wren  = w_granted & w_cur_wren;
    assign sys_mem_addr  = !w_granted ? '0 : (w_sel ? m1_addr : m0_addr);
    assign sys_mem_wdata = !w_granted ? '0 : (w_sel ? m1_wdata : m0_wdata);
    assign w_mem_acc     = (sys_mem_rden | sys_mem_wren) & ~sys_mem_wait;

    assign m0_wait = (state_q == GNT0) ? w_port_wait : 1'b1;
    assign m1_wait = (state_q == GNT1) ? w_port_wait : 1'b1;
    assign gnt     = {state_q == GNT1, state_q == GNT0};

    assign w_end_idle  = ~w_cur_req;
    assign w_end_burst = w_mem_acc & (burst_cnt_q == BURST_LAST);

    always_comb begin
        state_d       = state_q;
        last_gnt_d    = last_gnt_q;
        burst_cnt_d   = burst_cnt_q;
        w_grant_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_req0 && (!w_req1 || last_gnt_q)) begin
                    state_d       = GNT0;
                    w_grant_start = 1'b1;
                end else if (w_req1) begin
                    state_d       = GNT1;
                    w_grant_start = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (w_end_idle || w_end_burst) begin
                    if (w_other_req) begin
                        state_d       = w_sel ? GNT0 : GNT1;
                        w_grant_start = 1'b1;
                    end else if (w_end_idle) begin
                        state_d = IDLE;
                    end else begin
                        w_grant_start = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Every (re-)entry into a grant restarts the burst count.
        if (w_grant_start) begin
            burst_cnt_d = '0;
            last_gnt_d  = (state_d == GNT1);
        end else if (w_mem_acc) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    assign w_has_tag   = (outstd_q != '0);
    assign w_push      = sys_mem_rden & ~sys_mem_wait;
    assign w_pop       = sys_mem_rd_valid & w_has_tag;
    assign w_head      = tag_q[rd_ptr_q];
    assign m0_rd_valid = w_pop & ~w_head;
    assign m1_rd_valid = w_pop & w_head;
    assign m0_rdata    = sys_mem_rdata;
    assign m1_rdata    = sys_mem_rdata;
    assign rd_err      = rd_err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        outstd_d = outstd_q;
        rd_err_d = rd_err_q | (sys_mem_rd_valid & ~w_has_tag);
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   outstd_d = outstd_q + 1'b1;
            2'b01:   outstd_d = outstd_q - 1'b1;
            default: outstd_d = outstd_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            outstd_q    <= '0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            outstd_q    <= outstd_d;
            rd_err_q    <= rd_err_d;
        end
    end

    // Tag holds the issuing port id (1 = port 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_RD_OUTSTD; i++) begin
                tag_q[i] <= 1'b0;
            end
        end else if (w_push) begin
            tag_q[wr_ptr_q] <= w_sel;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sys_mem_arb.sv
// ============================================================================
// Module   : tb_sys_mem_arb
// Purpose  : Scoreboard bench for sys_mem_arb: directed scenarios plus random
//            traffic against a memory model and per-port expected-read queues.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sys_mem_arb;

    localparam int DW = 32;
    localparam int AW = 27;
    localparam int BL = 4;
    localparam int MO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_rden = 1'b0, m0_wren = 1'b0, m1_rden = 1'b0, m1_wren = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_wait, m1_wait, m0_rd_valid, m1_rd_valid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          sys_mem_wait = 1'b0, sys_mem_rd_valid = 1'b0;
    logic [DW-1:0] sys_mem_rdata = '0;
    logic          sys_mem_rden, sys_mem_wren;
    logic [AW-1:0] sys_mem_addr;
    logic [DW-1:0] sys_mem_wdata;
    logic [1:0]    gnt;
    logic          rd_err;

    sys_mem_arb #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .MAX_RD_OUTSTD(MO)) dut (
        .clk(clk), .rst(rst),
        .m0_rden(m0_rden), .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wait(m0_wait), .m0_rd_valid(m0_rd_valid), .m0_rdata(m0_rdata),
        .m1_rden(m1_rden), .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wait(m1_wait), .m1_rd_valid(m1_rd_valid), .m1_rdata(m1_rdata),
        .sys_mem_wait(sys_mem_wait), .sys_mem_rden(sys_mem_rden), .sys_mem_wren(sys_mem_wren),
        .sys_mem_addr(sys_mem_addr), .sys_mem_wdata(sys_mem_wdata),
        .sys_mem_rd_valid(sys_mem_rd_valid), .sys_mem_rdata(sys_mem_rdata),
        .gnt(gnt), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: what the requesters believe memory holds, and what each
    // port must get back, in order. The memory slave keeps its own copy.
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] slv_mem [int];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    logic [DW-1:0] pending [$];
    int            acc_port [$];
    int            acc_cyc [$];
    int            n_rd_acc, n_wr_acc, rdv_cnt0, rdv_cnt1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'hA500_0000 + 32'(a) * 32'h0000_0107;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] slv_rd(input int a);
        return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
    endfunction

    function automatic logic acc(input int p);
        return (p == 0) ? ((m0_rden | m0_wren) & ~m0_wait) : ((m1_rden | m1_wren) & ~m1_wait);
    endfunction

    // Observer: port-side handshakes feed the scoreboard, memory-side accepts feed the slave.
    always @(negedge clk) begin
        if (!rst) begin
            if (acc(0)) begin
                if (m0_rden) exp_q0.push_back(ref_rd(int'(m0_addr)));
                if (m0_wren) ref_mem[int'(m0_addr)] = m0_wdata;
            end
            if (acc(1)) begin
                if (m1_rden) exp_q1.push_back(ref_rd(int'(m1_addr)));
                if (m1_wren) ref_mem[int'(m1_addr)] = m1_wdata;
            end
            if ((sys_mem_rden | sys_mem_wren) && !sys_mem_wait) begin
                acc_port.push_back(gnt[1] ? 1 : 0);
                acc_cyc.push_back(cyc);
                if (sys_mem_rden) begin
                    pending.push_back(slv_rd(int'(sys_mem_addr)));
                    n_rd_acc++;
                end
                if (sys_mem_wren) begin
                    slv_mem[int'(sys_mem_addr)] = sys_mem_wdata;
                    n_wr_acc++;
                end
            end
            chk("grant_excl", ((gnt == 2'b11) || (gnt != 2'b01 && !m0_wait) ||
                               (gnt != 2'b10 && !m1_wait)) ? 1 : 0, 0);
        end
    end

    // Monitor: every returned read is compared with the head of its port's queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rd_valid) begin
                rdv_cnt0++;
                chk("rd0_expected", exp_q0.size() != 0, 1);
                if (exp_q0.size() != 0) chk("rd0_data", m0_rdata, exp_q0.pop_front());
            end
            if (m1_rd_valid) begin
                rdv_cnt1++;
                chk("rd1_expected", exp_q1.size() != 0, 1);
                if (exp_q1.size() != 0) chk("rd1_data", m1_rdata, exp_q1.pop_front());
            end
        end
    end

    task automatic set_port(input int p, input logic rd, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            m0_rden = rd; m0_wren = wr; m0_addr = a; m0_wdata = d;
        end else begin
            m1_rden = rd; m1_wren = wr; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Drive one request and hold it until accepted; returns just after a rising edge.
    task automatic issue(input int p, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic got = 1'b0;
        set_port(p, rd, wr, a, d);
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = acc(p);
            @(posedge clk); #1;
        end
        chk("issue_accepted", got, 1);
    endtask

    task automatic mem_return();
        chk("ret_pending", pending.size() != 0, 1);
        if (pending.size() != 0) begin
            sys_mem_rd_valid = 1'b1;
            sys_mem_rdata    = pending.pop_front();
            @(posedge clk); #1;
            sys_mem_rd_valid = 1'b0;
            sys_mem_rdata    = '0;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        sys_mem_wait = 1'b0; sys_mem_rd_valid = 1'b0; sys_mem_rdata = '0;
        exp_q0.delete(); exp_q1.delete(); pending.delete();
        acc_port.delete(); acc_cyc.delete(); ref_mem.delete(); slv_mem.delete();
        n_rd_acc = 0; n_wr_acc = 0; rdv_cnt0 = 0; rdv_cnt1 = 0;
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_wait", {m1_wait, m0_wait}, 2'b11);
        chk("rst_memreq", {sys_mem_rden, sys_mem_wren}, 0);
        chk("rst_memaddr", {sys_mem_addr, sys_mem_wdata}, 0);
        chk("rst_rdv_err", {m1_rd_valid, m0_rd_valid, rd_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_random(input int n);
        logic act [2];
        logic isrd [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        logic accd [2];
        act[0] = 0; act[1] = 0;
        for (int i = 0; i < n + 2000; i++) begin
            @(negedge clk);
            accd[0] = acc(0); accd[1] = acc(1);
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (act[p] && accd[p]) act[p] = 0;
                if (!act[p] && i < n && $urandom_range(0, 2) == 0) begin
                    act[p]  = 1;
                    isrd[p] = $urandom_range(0, 1) == 1;
                    ad[p]   = AW'($urandom_range(0, 15));
                    wd[p]   = $urandom;
                end
                set_port(p, act[p] & isrd[p], act[p] & ~isrd[p], ad[p], wd[p]);
            end
            sys_mem_wait = ($urandom_range(0, 3) == 0);
            if (pending.size() != 0 && $urandom_range(0, 1) == 1) begin
                sys_mem_rd_valid = 1'b1;
                sys_mem_rdata    = pending.pop_front();
            end else begin
                sys_mem_rd_valid = 1'b0;
                sys_mem_rdata    = '0;
            end
            if (i >= n && !act[0] && !act[1] && pending.size() == 0) break;
        end
        @(negedge clk);
        @(posedge clk); #1;
        sys_mem_rd_valid = 1'b0;
        sys_mem_wait     = 1'b0;
        @(negedge clk);
        chk("rand_q0_drained", exp_q0.size(), 0);
        chk("rand_q1_drained", exp_q1.size(), 0);
        chk("rand_rdv_total", rdv_cnt0 + rdv_cnt1, n_rd_acc);
        chk("rand_rd_err", rd_err, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Single requester: grant one cycle after request, four back-to-back reads.
        reset_dut();
        set_port(0, 1, 0, 27'd1, '0);
        @(negedge clk);
        chk("t1_idle_gnt", gnt, 2'b00);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_gnt", gnt, 2'b01);
            chk("t1_m0_wait", m0_wait, 0);
            @(posedge clk); #1;
            set_port(0, i < 3, 0, AW'(i + 2), '0);
        end
        chk("t1_acc", n_rd_acc, 4);
        repeat (4) mem_return();
        chk("t1_rdv", rdv_cnt0, 4);
        chk("t1_rd_err", rd_err, 0);

        // Both requesting continuously: 4-accept bursts alternate, port 0 first.
        reset_dut();
        fork
            begin
                for (int i = 0; i < 8; i++) issue(0, 0, 1, AW'(i), 32'h100 + i);
                set_port(0, 0, 0, '0, '0);
            end
            begin
                for (int i = 0; i < 8; i++) issue(1, 0, 1, AW'(i + 8), 32'h200 + i);
                set_port(1, 0, 0, '0, '0);
            end
        join
        chk("t2_acc_n", acc_port.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", (i < acc_port.size()) ? acc_port[i] : -1, (i / 4) % 2);
        end
        chk("t2_no_gap", (acc_cyc.size() == 16) ? acc_cyc[15] - acc_cyc[0] : -1, 15);

        // Outstanding-read limit on port 1.
        reset_dut();
        fork
            begin
                for (int i = 0; i < 10; i++) issue(1, 1, 0, AW'(i), '0);
                set_port(1, 0, 0, '0, '0);
            end
            begin
                int w = 0;
                while (n_rd_acc < 8 && w < 100) begin
                    @(posedge clk); #1;
                    w++;
                end
                chk("t3_reach8", n_rd_acc, 8);
                repeat (3) begin
                    @(negedge clk);
                    chk("t3_blk_wait", m1_wait, 1);
                    chk("t3_blk_rden", sys_mem_rden, 0);
                    @(posedge clk); #1;
                end
                chk("t3_still8", n_rd_acc, 8);
                mem_return();
                @(negedge clk);
                @(posedge clk); #1;
                chk("t3_one_more", n_rd_acc, 9);
                mem_return();
            end
        join
        while (pending.size() != 0) mem_return();
        chk("t3_rdv", rdv_cnt1, 10);
        chk("t3_q1_empty", exp_q1.size(), 0);

        // Interleaved ports: returns routed by tag order.
        reset_dut();
        issue(0, 1, 0, 27'd3, '0); set_port(0, 0, 0, '0, '0);
        issue(1, 1, 0, 27'd5, '0);
        issue(1, 1, 0, 27'd6, '0); set_port(1, 0, 0, '0, '0);
        issue(0, 1, 0, 27'd7, '0); set_port(0, 0, 0, '0, '0);
        issue(1, 1, 0, 27'd9, '0); set_port(1, 0, 0, '0, '0);
        repeat (5) mem_return();
        chk("t4_rdv0", rdv_cnt0, 2);
        chk("t4_rdv1", rdv_cnt1, 3);

        // Stray return: no routing, sticky error until reset.
        reset_dut();
        sys_mem_rd_valid = 1'b1;
        sys_mem_rdata    = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t5_no_rdv", {m1_rd_valid, m0_rd_valid}, 2'b00);
        @(posedge clk); #1;
        sys_mem_rd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_rd_err", rd_err, 1);

        // Memory stall during a port-1 write; stalled cycles do not count toward the burst.
        reset_dut();
        sys_mem_wait = 1'b1;
        set_port(1, 0, 1, 27'd9, 32'hCAFE_0009);
        @(posedge clk); #1;
        set_port(0, 0, 1, 27'd2, 32'h0000_0002);
        repeat (5) begin
            @(negedge clk);
            chk("t6_gnt", gnt, 2'b10);
            chk("t6_m1_wait", m1_wait, 1);
            @(posedge clk); #1;
        end
        chk("t6_no_acc", n_wr_acc, 0);
        sys_mem_wait = 1'b0;
        @(negedge clk);
        chk("t6_m1_go", m1_wait, 0);
        @(posedge clk); #1;
        chk("t6_acc", n_wr_acc, 1);
        chk("t6_data", slv_mem.exists(9) ? slv_mem[9] : '0, 32'hCAFE_0009);
        for (int k = 1; k < 4; k++) begin
            set_port(1, 0, 1, AW'(9 + k), 32'hCAFE_0000 + k);
            @(negedge clk);
            @(posedge clk); #1;
        end
        set_port(1, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        set_port(0, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            chk("t6_order", (i < acc_port.size()) ? acc_port[i] : -1, (i < 4) ? 1 : 0);
        end

        // Randomized mixed traffic.
        reset_dut();
        run_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sys_mem_arb.md
# sys_mem_arb

Two-port arbiter sharing the single system-memory master port between the video fetch path (port 0, the line-buffer read requester) and a general read/write requester (port 1, e.g. the frame renderer). Grants are burst-based round-robin, and read data is returned to the issuing port in order via a tag FIFO. Sits between the requesters and the `sys_mem_*` interface, in the `clk` domain.

## Interface
- `DATA_W`, 32, system-memory data width
- `ADDR_W`, 27, system-memory address width
- `BURST_LEN`, 16, max accepted transfers per grant (≥1)
- `MAX_RD_OUTSTD`, 8, max reads in flight (tag FIFO depth, ≥1)

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `m0_rden`, `m0_wren`  in  1  port 0 requests (same for `m1_*`)
- `m0_addr`  in  ADDR_W  port 0 address (same for `m1_*`)
- `m0_wdata`  in  DATA_W  port 0 write data (same for `m1_*`)
- `m0_wait`  out  1  port 0 stall; request accepted when request high and wait low (same for `m1_*`)
- `m0_rd_valid`  out  1  read data valid for port 0 (same for `m1_*`)
- `m0_rdata`, `m1_rdata`  out  DATA_W  both driven from `sys_mem_rdata`
- `sys_mem_wait`  in  1  memory stall
- `sys_mem_rden`, `sys_mem_wren`  out  1  memory requests
- `sys_mem_addr`  out  ADDR_W
- `sys_mem_wdata`  out  DATA_W
- `sys_mem_rd_valid`  in  1; `sys_mem_rdata`  in  DATA_W
- `gnt`  out  2  one-hot current grant {port1, port0}; 0 in IDLE
- `rd_err`  out  1  sticky: rd_valid received with no outstanding tag

## Operation
- `mX_req` = `mX_rden | mX_wren`. Port 0 is read-only by use, but the block does not enforce it.
- FSM states are IDLE, GNT0 and GNT1. A register `last_gnt` resets to 1, so port 0 wins the first tie.
- IDLE: both waits are 1. No sys_mem request is issued. Next state:
  - one requester → that port's grant state
  - both requesting → the port ≠ `last_gnt`
- GNTx (granted port x):
  - `sys_mem_rden/wren/addr/wdata` follow port x combinationally. `mX_wait = sys_mem_wait | rd_block`.
  - The other port's wait is 1. Its request is not forwarded.
- `rd_block` = `mX_rden & (outstd == MAX_RD_OUTSTD)`. When high, `sys_mem_rden` is forced 0. Writes are never blocked by it.
- Accept = `sys_mem_rden|sys_mem_wren` high and `sys_mem_wait` low. Each accept increments `burst_cnt`.
- `burst_cnt` clears on entry to any grant state.
- A grant ends when either:
  - (a) `mX_req` = 0 in a GNTx cycle, or
  - (b) an accept happens with `burst_cnt == BURST_LEN-1`.
- On grant end, the next state is GNT(other) if the other port requests. Otherwise:
  - case (a) → IDLE
  - case (b) → GNTx again, with counter cleared
- `last_gnt` updates to x on every entry to GNTx.
- Simultaneous rden and wren from one port: both are forwarded unchanged; the memory's behaviour governs. Each accepted read pushes a tag regardless.
- Tag FIFO: depth MAX_RD_OUTSTD, 1-bit entries.
  - An accepted read pushes the port id.
  - `sys_mem_rd_valid` pops the head and asserts `m<head>_rd_valid` in the same cycle, combinationally.
  - Push and pop in the same cycle are allowed.
  - `outstd` width is clog2(MAX_RD_OUTSTD+1).
- `sys_mem_rd_valid` with an empty FIFO: no port rd_valid, no pop, `rd_err` ← 1 until reset.

## Timing
- Reset values:
  - state IDLE, `gnt` = 0
  - `m0_wait` = `m1_wait` = 1
  - `sys_mem_rden/wren` = 0; `sys_mem_addr/wdata` = 0 (IDLE drives 0)
  - `mX_rd_valid` = 0, `rd_err` = 0
  - FIFO empty, `outstd` = 0, `burst_cnt` = 0
- Grant latency is one cycle: a request seen in IDLE → GNT and wait low (absent stall) in the next cycle. Handover GNTx→GNTy has no idle cycle.
- Request-to-memory latency in GNT is 0 cycles, combinational pass-through.
- Read return latency is 0 cycles added.
- Requesters hold addr, wdata and request stable while wait is high.
- Reset mid-operation returns the FSM to IDLE immediately and discards tags. Reads still returning afterward set `rd_err`. Reset is asserted only with memory quiescent.

## Test plan
- Reset, then m0 issues 4 reads, memory no-wait → `gnt`=01 in cycle 1, 4 accepts, 4 `m0_rd_valid` in order, `rd_err`=0.
- Both request continuously, `BURST_LEN`=4 → grants alternate GNT0 (4 accepts), GNT1 (4 accepts) with no idle cycle; port 0 is granted first.
- m1 issues 10 reads with memory returning none, `MAX_RD_OUTSTD`=8 → 8 accepts, then `m1_wait`=1 and `sys_mem_rden`=0. One `rd_valid` → one more accept.
- Interleaved m0/m1 reads outstanding, returns in order → each `rd_valid` routed to the matching port per tag sequence.
- `sys_mem_rd_valid` pulse with `outstd`=0 → no port `rd_valid`; `rd_err`=1 and stays 1 until `rst`.
- `sys_mem_wait`=1 for 5 cycles during GNT1 write → `m1_wait`=1 for those cycles, no accept and no `burst_cnt` change. Write accepted on the first wait-low cycle.
